// File: rtl/rb_spi_responder.sv
// SPI mode-0 responder: turns host frames into single-clk register-bank read/write strobes.
// All SPI pins are synchronised into clk; MISO, address, data and strobes are registered.
//   state  | meaning
//   IDLE   | cs_n high or frame aborted; waits for a fresh falling cs_n
//   CMD    | shifting in the command byte (rw bit + start address)
//   DATA   | burst data bytes; address advances after every byte
module rb_spi_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic [ADDR_W-1:0] rb_addr_o,
    output logic [DATA_W-1:0] rb_wdata_o,
    output logic              rb_we_o,
    output logic              rb_re_o,
    input  logic [DATA_W-1:0] rb_rdata_i,
    output logic              frame_err_o
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic                   r_armed;

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_tx;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rw;
    logic              r_we;
    logic              r_re;
    logic              r_cap;
    logic              r_miso;
    logic              r_err;

    logic              w_sclk_s;
    logic              w_cs_s;
    logic              w_mosi_s;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic [DATA_W-1:0] w_byte;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_byte_done;
    logic              w_start;
    logic              w_cmd_done;
    logic              w_data_done;
    logic              w_frame_err;

    // Sync chains reset low, so a cs_n held low across reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_armed     <= r_armed | w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_byte      = {r_shift[DATA_W-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_cs_rise)        w_state_nxt = S_IDLE;
                else if (w_byte_done) w_state_nxt = S_DATA;
            end
            S_DATA:  if (w_cs_rise) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A sclk edge coincident with cs_n rising is counted before the frame is judged.
    always_comb begin
        w_cnt_nxt   = r_bit_cnt;
        w_byte_done = 1'b0;
        w_start     = 1'b0;
        w_cmd_done  = 1'b0;
        w_data_done = 1'b0;
        w_frame_err = 1'b0;
        if (w_sclk_rise)
            w_cnt_nxt = (r_bit_cnt == CNT_FULL) ? CNT_ONE : r_bit_cnt + CNT_ONE;
        if (r_state == S_IDLE) begin
            w_start = w_cs_fall;
        end else begin
            w_byte_done = w_sclk_rise && (r_bit_cnt == CNT_LAST);
            w_cmd_done  = w_byte_done && (r_state == S_CMD);
            w_data_done = w_byte_done && (r_state == S_DATA);
            w_frame_err = w_cs_rise && (w_cnt_nxt != CNT_ZERO) && (w_cnt_nxt != CNT_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rw      <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_cap     <= 1'b0;
            r_miso    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_we  <= w_data_done & r_rw;
            r_re  <= (w_cmd_done & ~w_byte[DATA_W-1]) | (w_data_done & ~r_rw);
            r_cap <= r_re;
            r_err <= w_frame_err;

            if (w_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (r_state != S_IDLE) begin
                r_bit_cnt <= w_cnt_nxt;
                if (w_sclk_rise) r_shift <= w_byte;
            end

            if (w_cmd_done) r_rw <= w_byte[DATA_W-1];
            if (w_data_done && r_rw) r_wdata <= w_byte;

            // Writes hold the address through the strobe and advance afterwards;
            // reads advance first so the prefetch strobe carries the next address.
            if (w_cmd_done)
                r_addr <= w_byte[ADDR_W-1:0];
            else if ((w_data_done && !r_rw) || r_we)
                r_addr <= r_addr + ADDR_ONE;

            if (r_cap)
                r_tx <= rb_rdata_i;
            else if (r_state == S_DATA && !r_rw && w_sclk_fall)
                r_tx <= {r_tx[DATA_W-2:0], 1'b0};

            if (r_state == S_IDLE)
                r_miso <= 1'b0;
            else if (w_sclk_fall)
                r_miso <= (r_state == S_DATA && !r_rw) ? r_tx[DATA_W-1] : 1'b0;
        end
    end

    assign spi_miso_o    = r_miso;
    assign spi_miso_oe_o = r_armed & ~w_cs_s;
    assign rb_addr_o     = r_addr;
    assign rb_wdata_o    = r_wdata;
    assign rb_we_o       = r_we;
    assign rb_re_o       = r_re;
    assign frame_err_o   = r_err;

endmodule

// File: doc/rb_spi_responder.md
Name: rb_spi_responder

Overview:
- SPI mode-0 slave that turns host SPI frames into single-cycle register-bank read/write strobes.
- Its address/data/strobe outputs drive the register bank that produces the sys_cfg, dsp_cfg and sampler_cfg wire structs.
- Read data from the bank is shifted back on MISO.
- Sits between the FPGA SPI pins and the register bank, entirely in the system clock domain.

Parameters:
- ADDR_W, 7, register address width; the command byte carries the address in bits [ADDR_W-1:0].
- DATA_W, 8, register data width; one data byte per register.
- SYNC_STAGES, 2, flip-flop stages on the sclk/cs_n/mosi synchronisers (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_sclk_i  input  1  SPI clock from host, asynchronous to clk
- spi_cs_n_i  input  1  SPI chip select, active low
- spi_mosi_i  input  1  host-to-slave data, MSB first
- spi_miso_o  output  1  slave-to-host data
- spi_miso_oe_o  output  1  MISO output enable, high while the synchronised cs_n is low
- rb_addr_o  output  ADDR_W  register address for the current access
- rb_wdata_o  output  DATA_W  register write data
- rb_we_o  output  1  one-clk write strobe
- rb_re_o  output  1  one-clk read strobe
- rb_rdata_i  input  DATA_W  register read data, valid exactly 1 clk after rb_re_o
- frame_err_o  output  1  one-clk pulse when a frame ends on a partial byte

Behaviour:
- Reset values: all outputs 0, state IDLE, bit counter 0, shift registers 0.
- Synchronisation and timing:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected from the last two synchronised samples.
  - The host guarantees f_sclk <= f_clk/8.
- Frame format:
  - Command byte: bit7 = 1 for write, 0 for read; bits [ADDR_W-1:0] = start address.
  - Then one or more data bytes (burst).
- States:
  - IDLE: cs_n high. A falling cs_n clears the bit counter and goes to CMD.
  - CMD: shift mosi in on each rising sclk. After the 8th bit, latch rw and rb_addr_o.
    - Read: pulse rb_re_o for 1 clk; the next clk captures rb_rdata_i into the TX shift register. Go to DATA.
    - Write: go to DATA.
  - DATA: 8 rising edges per byte.
    - Write: after the 8th bit, set rb_wdata_o to the byte and pulse rb_we_o for 1 clk with the current address. Then increment the address.
    - Read: at the 8th rising edge, increment the address and pulse rb_re_o for the prefetch. The captured data reloads the TX register before the next falling edge.
- MISO:
  - Updated on falling sclk edges only.
  - Drives 0 throughout the command byte.
  - In DATA/read, drives TX bit7 first, then shifts left.
  - In DATA/write, drives 0.
- Address increment wraps from 2^ADDR_W-1 to 0. The rw bit is fixed for the whole frame.
- cs_n rising (synchronised) in any state returns to IDLE on the next clk:
  - Bit counter 0 or 8 (byte boundary): no error.
  - Otherwise: pulse frame_err_o. The partial byte is discarded and no write is issued.
  - A read strobe already issued is not retracted.
- cs_n rising in the same clk as the 8th data rising edge: the write still completes (the edge is processed first), then IDLE.
- rb_we_o and rb_re_o are never high in the same clk.
- Each strobe is exactly 1 clk regardless of the clk/sclk ratio.
- Asynchronous reset mid-frame: immediate return to reset values. The next frame requires a fresh cs_n falling edge.

Test Plan:
- Write single, addr 0x05, data 0xA5 (cmd 0x85) -> exactly one rb_we_o pulse with rb_addr_o=0x05 and rb_wdata_o=0xA5; rb_re_o never asserted.
- Read single, cmd 0x12, model returns 0x3C for addr 0x12 -> rb_re_o pulses once with addr 0x12; the host samples 0x3C on MISO during the second byte; MISO is 0 during the command byte.
- Write burst from addr 0x7E with data 0x11, 0x22, 0x33 -> three rb_we_o pulses at addresses 0x7E, 0x7F, 0x00 (wrap) with the matching data.
- Read burst of 3 bytes from addr 0x20 returning 0x01, 0x02, 0x03 -> MISO bytes 0x01, 0x02, 0x03; rb_re_o issued at 0x20, 0x21, 0x22 and a prefetch at 0x23.
- cs_n raised after 12 bits of a write to addr 0x04 -> no rb_we_o, one frame_err_o pulse; a following full write to addr 0x04 with data 0x5A succeeds.
- rst_n asserted mid data byte -> all outputs 0 immediately, no strobe; after release, a complete write frame is processed correctly.
- Run all of the above at the minimum clock ratio f_sclk = f_clk/8.
